// File: rtl/jk_drive_pkg.sv
// Shared opcodes, FSM state encoding and JK next-state helper
// for the jk_drive_seq sequencer and its shadow checker.
package jk_drive_pkg;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Characteristic equation of a JK flop: {j,k} -> next q.
  function automatic logic jk_next(
    input logic       q,
    input logic [1:0] jk
  );
    logic nq;
    nq = q;
    case (jk)
      OP_RESET:  nq = 1'b0;
      OP_SET:    nq = 1'b1;
      OP_TOGGLE: nq = ~q;
      default:   nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_shadow_chk.sv
// Shadow model of the downstream JK flop plus sticky feedback compare.
// Ports: clk, reset (async high), jk (registered drive), q_fb/qbar_fb, mismatch.
module jk_shadow_chk
  import jk_drive_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] jk,
  input  logic       q_fb,
  input  logic       qbar_fb,
  output logic       mismatch
);

  logic exp_q, exp_d;
  logic mis_q, mis_d;
  logic bad;

  always_comb begin
    bad   = (q_fb != exp_q) || (q_fb == qbar_fb);
    exp_d = jk_next(exp_q, jk);
    mis_d = mis_q | bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      mis_q <= mis_d;
    end
  end

  assign mismatch = mis_q;

endmodule

// File: rtl/jk_drive_seq.sv
// Command sequencer driving {j,k} of one JK stage for cmd_len clocks,
// then pulsing done. Ports: clk, reset (async high), cmd_valid/ready,
// cmd_op, cmd_len, j, k, busy, done, q_fb, qbar_fb, mismatch.
// Macro JK_DRIVE_QCHECK_EN enables the q/qbar shadow checker.
module jk_drive_seq
  import jk_drive_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  input  logic             q_fb,
  input  logic             qbar_fb,
  output logic             mismatch
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       jk_q, jk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic [CNT_W-1:0] len_m1;

  assign cmd_ready = (state_q != ST_DRIVE);
  assign accept    = cmd_valid && cmd_ready;

  // A zero length runs for one cycle, same as length one.
  assign len_m1 = (cmd_len == '0) ? '0
                : cmd_len - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    jk_d    = jk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        jk_d    = OP_HOLD;
        busy_d  = 1'b0;
        if (accept) begin
          state_d = ST_DRIVE;
          cnt_d   = len_m1;
          op_d    = cmd_op;
          jk_d    = cmd_op;
          busy_d  = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          jk_d  = op_q;
        end else begin
          state_d = ST_DONE;
          jk_d    = OP_HOLD;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        jk_d    = OP_HOLD;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      jk_q    <= OP_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      jk_q    <= jk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign j    = jk_q[1];
  assign k    = jk_q[0];
  assign busy = busy_q;
  assign done = done_q;

`ifdef JK_DRIVE_QCHECK_EN
  jk_shadow_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .jk       (jk_q),
    .q_fb     (q_fb),
    .qbar_fb  (qbar_fb),
    .mismatch (mismatch)
  );
`else
  logic unused_fb;
  assign unused_fb = q_fb ^ qbar_fb;
  assign mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_jk_drive_seq.sv
// Self-checking bench for jk_drive_seq with a looped-back JK stage.
// Directed scenarios plus randomized commands against a behavioural model.
module tb_jk_drive_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_len = 8'd0;
  logic       j, k, busy, done;
  logic       q_fb, qbar_fb, mismatch;
  logic       fq, fqb;
  logic       force_q0 = 1'b0;
  logic       mq;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 clk = ~clk;

  jk_drive_seq #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .done      (done),
    .q_fb      (q_fb),
    .qbar_fb   (qbar_fb),
    .mismatch  (mismatch)
  );

  // Downstream JK stage sharing clk and reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fq  <= 1'b0;
      fqb <= 1'b1;
    end else begin
      case ({j, k})
        2'b01: begin fq <= 1'b0; fqb <= 1'b1; end
        2'b10: begin fq <= 1'b1; fqb <= 1'b0; end
        2'b11: begin fq <= ~fq;  fqb <= fq;   end
        default: ;
      endcase
    end
  end

  assign q_fb    = force_q0 ? 1'b0 : fq;
  assign qbar_fb = fqb;

  function automatic logic model_q(input logic q, input logic [1:0] op, input int cycles);
    case (op)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return q ^ logic'(cycles % 2);
      default: return q;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #2;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    logic [6:0] obs;
    #2 reset = 1'b1;
    #1;
    obs = {j, k, busy, done, cmd_ready, mismatch, fq};
    n_total++;
    if (obs !== 7'b0000100) $display("FAIL rst_async: got %b want 0000100", obs);
    else n_pass++;
    tick; tick;
    obs = {j, k, busy, done, cmd_ready, mismatch, fq};
    n_total++;
    if (obs !== 7'b0000100) $display("FAIL rst_held: got %b want 0000100", obs);
    else n_pass++;
    reset = 1'b0;
    tick;
    obs = {j, k, busy, done, cmd_ready, mismatch, fq};
    n_total++;
    if (obs !== 7'b0000100) $display("FAIL rst_release: got %b want 0000100", obs);
    else n_pass++;
  endtask

  task automatic test_toggle3;
    logic [4:0] obs;
    mq = 1'b0;
    cmd_op = 2'b11; cmd_len = 8'd3; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      obs = {j, k, busy, done, cmd_ready};
      n_total++;
      if (obs !== 5'b11100) $display("FAIL tgl_drive%0d: got %b want 11100", i, obs);
      else n_pass++;
      tick;
      mq = model_q(mq, 2'b11, 1);
      n_total++;
      if (fq !== mq) $display("FAIL tgl_q%0d: got %b want %b", i, fq, mq);
      else n_pass++;
    end
    obs = {j, k, busy, done, cmd_ready};
    n_total++;
    if (obs !== 5'b00011) $display("FAIL tgl_done: got %b want 00011", obs);
    else n_pass++;
    tick;
    obs = {j, k, busy, done, cmd_ready};
    n_total++;
    if (obs !== 5'b00001) $display("FAIL tgl_idle: got %b want 00001", obs);
    else n_pass++;
    n_total++;
    if (mismatch !== 1'b0) $display("FAIL tgl_mis: got %b want 0", mismatch);
    else n_pass++;
  endtask

  task automatic test_set_len0;
    logic [4:0] obs;
    int ndone;
    cmd_op = 2'b10; cmd_len = 8'd0; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    obs = {j, k, busy, done, cmd_ready};
    n_total++;
    if (obs !== 5'b10100) $display("FAIL set0_drive: got %b want 10100", obs);
    else n_pass++;
    tick;
    obs = {j, k, busy, done, cmd_ready};
    n_total++;
    if ({obs, fq} !== 6'b000111) $display("FAIL set0_done: got %b want 000111", {obs, fq});
    else n_pass++;
    cmd_op = 2'b01; cmd_len = 8'd2; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    obs = {j, k, busy, done, cmd_ready};
    n_total++;
    if (obs !== 5'b01100) $display("FAIL rst2_drive: got %b want 01100", obs);
    else n_pass++;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (done === 1'b1) ndone++;
    end
    n_total++;
    if (ndone != 1) $display("FAIL rst2_ndone: got %0d want 1", ndone);
    else n_pass++;
    n_total++;
    if (fq !== 1'b0) $display("FAIL rst2_q: got %b want 0", fq);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [4:0] obs;
    cmd_op = 2'b00; cmd_len = 8'd5; cmd_valid = 1'b1;
    tick;
    cmd_op = 2'b11; cmd_len = 8'd2;
    for (int i = 0; i < 5; i++) begin
      obs = {j, k, busy, done, cmd_ready};
      n_total++;
      if (obs !== 5'b00100) $display("FAIL b2b_hold%0d: got %b want 00100", i, obs);
      else n_pass++;
      tick;
    end
    obs = {j, k, busy, done, cmd_ready};
    n_total++;
    if (obs !== 5'b00011) $display("FAIL b2b_done: got %b want 00011", obs);
    else n_pass++;
    tick;
    cmd_valid = 1'b0;
    obs = {j, k, busy, done, cmd_ready};
    n_total++;
    if (obs !== 5'b11100) $display("FAIL b2b_nogap: got %b want 11100", obs);
    else n_pass++;
    tick;
    tick;
    obs = {j, k, busy, done, cmd_ready};
    n_total++;
    if ({obs, fq} !== 6'b000110) $display("FAIL b2b_end: got %b want 000110", {obs, fq});
    else n_pass++;
    tick;
  endtask

  task automatic test_reset_mid;
    logic [6:0] obs;
    cmd_op = 2'b11; cmd_len = 8'd10; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick; tick; tick;
    #2 reset = 1'b1;
    #1;
    obs = {j, k, busy, done, cmd_ready, mismatch, fq};
    n_total++;
    if (obs !== 7'b0000100) $display("FAIL rmid_async: got %b want 0000100", obs);
    else n_pass++;
    tick;
    reset = 1'b0;
    tick;
    cmd_op = 2'b10; cmd_len = 8'd1; cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
    obs = {j, k, busy, done, cmd_ready, mismatch, fq};
    n_total++;
    if (obs !== 7'b1010000) $display("FAIL rmid_set: got %b want 1010000", obs);
    else n_pass++;
    tick;
    obs = {j, k, busy, done, cmd_ready, mismatch, fq};
    n_total++;
    if (obs !== 7'b0001101) $display("FAIL rmid_done: got %b want 0001101", obs);
    else n_pass++;
    tick;
  endtask

  task automatic test_mismatch;
    logic want;
`ifdef JK_DRIVE_QCHECK_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    do_reset;
    cmd_op = 2'b10; cmd_len = 8'd2; cmd_valid = 1'b1;
    force_q0 = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    n_total++;
    if (mismatch !== 1'b0) $display("FAIL mis_early: got %b want 0", mismatch);
    else n_pass++;
    tick;
    n_total++;
    if (mismatch !== want) $display("FAIL mis_rise: got %b want %b", mismatch, want);
    else n_pass++;
    force_q0 = 1'b0;
    tick; tick; tick;
    n_total++;
    if (mismatch !== want) $display("FAIL mis_sticky: got %b want %b", mismatch, want);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (mismatch !== 1'b0) $display("FAIL mis_clear: got %b want 0", mismatch);
    else n_pass++;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_random;
    logic [4:0] obs;
    logic [1:0] op;
    int len, l, gap;
    do_reset;
    mq = 1'b0;
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 6);
      l   = (len == 0) ? 1 : len;
      cmd_op = op; cmd_len = 8'(len); cmd_valid = 1'b1;
      n_total++;
      if (cmd_ready !== 1'b1) $display("FAIL rnd_ready%0d: got %b want 1", n, cmd_ready);
      else n_pass++;
      tick;
      for (int c = 0; c < l; c++) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_len   = 8'($urandom_range(0, 255));
        obs = {j, k, busy, done, cmd_ready};
        n_total++;
        if (obs !== {op, 3'b100}) $display("FAIL rnd_drive%0d: got %b want %b", n, obs, {op, 3'b100});
        else n_pass++;
        tick;
        mq = model_q(mq, op, 1);
        n_total++;
        if (fq !== mq) $display("FAIL rnd_q%0d: got %b want %b", n, fq, mq);
        else n_pass++;
      end
      cmd_valid = 1'b0;
      obs = {j, k, busy, done, cmd_ready};
      n_total++;
      if (obs !== 5'b00011) $display("FAIL rnd_done%0d: got %b want 00011", n, obs);
      else n_pass++;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick;
        obs = {j, k, busy, done, cmd_ready};
        n_total++;
        if ({obs, fq} !== {5'b00001, mq}) $display("FAIL rnd_idle%0d: got %b want %b", n, {obs, fq}, {5'b00001, mq});
        else n_pass++;
      end
    end
    n_total++;
    if (mismatch !== 1'b0) $display("FAIL rnd_mis: got %b want 0", mismatch);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_toggle3;
    test_set_len0;
    test_back_to_back;
    test_reset_mid;
    test_mismatch;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
